// File: rtl/ysyx_22051468_bus_arbiter.sv
// Round-robin arbiter sharing one downstream request/response port between NR_REQ requesters.
// One transaction in flight at a time; the grant is held from arbitration until the response returns.
module ysyx_22051468_bus_arbiter #(
   parameter int NR_REQ      = 2,
   parameter int PAYLOAD_LEN = 64,
   parameter int RSP_LEN     = 32,
   localparam int IDX_LEN    = $clog2(NR_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NR_REQ-1:0]             req_valid,
   input  logic [NR_REQ*PAYLOAD_LEN-1:0] req_payload,
   output logic [NR_REQ-1:0]             req_ready,
   output logic [NR_REQ-1:0]             rsp_valid,
   output logic [RSP_LEN-1:0]            rsp_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [PAYLOAD_LEN-1:0]        m_payload,
   output logic [IDX_LEN-1:0]            m_id,
   input  logic                          s_rsp_valid,
   input  logic [RSP_LEN-1:0]            s_rsp_data
);

   // Handshake: a downstream request transfers on a cycle with m_valid && m_ready;
   // req_ready[n] is that same transfer seen from requester n, and rsp_valid[n]
   // is a one-cycle strobe qualifying the broadcast rsp_data.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_LEN-1:0] grant_q, grant_d;
   logic [IDX_LEN-1:0] ptr_q, ptr_d;
   logic               m_valid_q, m_valid_d;

   logic [IDX_LEN-1:0] pick_idx;
   logic               pick_found;

   // Search starts at ptr and wraps at NR_REQ-1, so unused index codes never appear.
   always_comb begin
      int                 cand;
      logic [IDX_LEN-1:0] cand_idx;
      pick_idx   = '0;
      pick_found = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 0; i < NR_REQ; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= NR_REQ) cand = cand - NR_REQ;
         cand_idx = IDX_LEN'(cand);
         if (!pick_found && req_valid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      m_valid_d = m_valid_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d   = pick_idx;
               state_d   = S_REQ;
               m_valid_d = 1'b1;
            end
         end
         S_REQ: begin
            if (m_ready) begin
               state_d   = S_WAIT;
               m_valid_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (s_rsp_valid) begin
               ptr_d   = (grant_q == IDX_LEN'(NR_REQ - 1)) ? '0 : grant_q + IDX_LEN'(1);
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            m_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         m_valid_q <= m_valid_d;
      end
   end

   // Strobes and the payload mux are keyed on the held grant, gated by the phase.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      m_payload = '0;
      for (int n = 0; n < NR_REQ; n++) begin
         if (grant_q == IDX_LEN'(n)) begin
            req_ready[n] = (state_q == S_REQ) && m_ready;
            rsp_valid[n] = (state_q == S_WAIT) && s_rsp_valid;
            if (state_q == S_REQ) m_payload = m_payload | req_payload[n*PAYLOAD_LEN +: PAYLOAD_LEN];
         end
      end
   end

   assign m_valid  = m_valid_q;
   assign m_id     = grant_q;
   assign rsp_data = s_rsp_data;

endmodule
